// File: rtl/vga_sync_gen.sv
// vga_sync_gen: programmable video timing generator with test-pattern pixels.
// Timing inputs use the cumulative convention (width, front-porch end,
// sync end, raw total). They are shadowed while idle and at each frame wrap,
// so changes made mid-frame take effect at the next frame.
module vga_sync_gen #(
  parameter logic OPT_INVERT_HSYNC = 1'b1,
  parameter logic OPT_INVERT_VSYNC = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic [15:0] i_width,
  input  logic [15:0] i_hfront,
  input  logic [15:0] i_hsync,
  input  logic [15:0] i_raw_width,
  input  logic [15:0] i_height,
  input  logic [15:0] i_vfront,
  input  logic [15:0] i_vsync,
  input  logic [15:0] i_raw_height,
  output logic        o_pix_valid,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [22:0] o_pixel,
  output logic        o_frame_start,
  output logic        o_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] hpos;
  logic [15:0] vpos;
  logic [6:0]  frame;

  logic [15:0] s_width;
  logic [15:0] s_hfront;
  logic [15:0] s_hsync;
  logic [15:0] s_raw_width;
  logic [15:0] s_height;
  logic [15:0] s_vfront;
  logic [15:0] s_vsync;
  logic [15:0] s_raw_height;

  logic in_valid;
  logic line_end;
  logic frame_end;
  logic pv;
  logic hs;
  logic vs;

  // Validity of the live timing inputs (all comparisons unsigned 16-bit).
  always_comb begin
    in_valid = (i_width != '0) && (i_width <= i_hfront) &&
               (i_hfront < i_hsync) && (i_hsync <= i_raw_width) &&
               (i_height != '0) && (i_height <= i_vfront) &&
               (i_vfront < i_vsync) && (i_vsync <= i_raw_height);
  end

  // Line and frame end detection against the shadowed totals.
  always_comb begin
    line_end  = (hpos == s_raw_width - 16'd1);
    frame_end = line_end && (vpos == s_raw_height - 16'd1);
  end

  // Pixel-position decode from the current counters and shadow timing.
  always_comb begin
    pv = (hpos < s_width) && (vpos < s_height);
    hs = (hpos >= s_hfront) && (hpos < s_hsync);
    vs = (vpos >= s_vfront) && (vpos < s_vsync);
  end

  // State machine, counters, shadow timing registers and error flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      hpos         <= '0;
      vpos         <= '0;
      frame        <= '0;
      o_err        <= 1'b0;
      s_width      <= '0;
      s_hfront     <= '0;
      s_hsync      <= '0;
      s_raw_width  <= '0;
      s_height     <= '0;
      s_vfront     <= '0;
      s_vsync      <= '0;
      s_raw_height <= '0;
    end else begin
      case (state)
        IDLE: begin
          hpos         <= '0;
          vpos         <= '0;
          frame        <= '0;
          o_err        <= !in_valid;
          s_width      <= i_width;
          s_hfront     <= i_hfront;
          s_hsync      <= i_hsync;
          s_raw_width  <= i_raw_width;
          s_height     <= i_height;
          s_vfront     <= i_vfront;
          s_vsync      <= i_vsync;
          s_raw_height <= i_raw_height;
          if (i_en && in_valid) state <= RUN;
        end
        RUN: begin
          if (frame_end) begin
            s_width      <= i_width;
            s_hfront     <= i_hfront;
            s_hsync      <= i_hsync;
            s_raw_width  <= i_raw_width;
            s_height     <= i_height;
            s_vfront     <= i_vfront;
            s_vsync      <= i_vsync;
            s_raw_height <= i_raw_height;
          end
          if (!i_en) begin
            // Abort: a disable coinciding with the wrap still reports the
            // validity of the newly latched timing.
            state <= IDLE;
            hpos  <= '0;
            vpos  <= '0;
            frame <= '0;
            if (frame_end) o_err <= !in_valid;
          end else if (frame_end) begin
            hpos  <= '0;
            vpos  <= '0;
            frame <= frame + 7'd1;
            if (!in_valid) begin
              state <= IDLE;
              o_err <= 1'b1;
            end
          end else if (line_end) begin
            hpos <= '0;
            vpos <= vpos + 16'd1;
          end else begin
            hpos <= hpos + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered outputs, one clock behind the counters; inactive unless running.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pix_valid   <= 1'b0;
      o_hsync       <= OPT_INVERT_HSYNC;
      o_vsync       <= OPT_INVERT_VSYNC;
      o_pixel       <= '0;
      o_frame_start <= 1'b0;
    end else if (state == RUN && i_en) begin
      o_pix_valid   <= pv;
      o_hsync       <= hs ^ OPT_INVERT_HSYNC;
      o_vsync       <= vs ^ OPT_INVERT_VSYNC;
      o_pixel       <= pv ? {hpos[7:0], vpos[7:0], frame} : '0;
      o_frame_start <= pv && (hpos == '0) && (vpos == '0);
    end else begin
      o_pix_valid   <= 1'b0;
      o_hsync       <= OPT_INVERT_HSYNC;
      o_vsync       <= OPT_INVERT_VSYNC;
      o_pixel       <= '0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: stimulus pushes expected outputs into a
// scoreboard queue, a monitor pops and compares at each falling edge.
module tb_vga_sync_gen;

  localparam logic INV_H = 1'b1;
  localparam logic INV_V = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] width = '0, hfront = '0, hsync = '0, raw_width = '0;
  logic [15:0] height = '0, vfront = '0, vsync = '0, raw_height = '0;
  logic        pix_valid, hsync_o, vsync_o, frame_start, err;
  logic [22:0] pixel;

  vga_sync_gen #(.OPT_INVERT_HSYNC(INV_H), .OPT_INVERT_VSYNC(INV_V)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
    .i_width(width), .i_hfront(hfront), .i_hsync(hsync), .i_raw_width(raw_width),
    .i_height(height), .i_vfront(vfront), .i_vsync(vsync), .i_raw_height(raw_height),
    .o_pix_valid(pix_valid), .o_hsync(hsync_o), .o_vsync(vsync_o),
    .o_pixel(pixel), .o_frame_start(frame_start), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        fs;
    logic        pv;
    logic        hs;
    logic        vs;
    logic [22:0] pix;
  } obs_t;

  obs_t  q[$];
  string tags[$];
  int    checks = 0;
  int    errors = 0;
  obs_t  m_exp, m_act;
  string m_tag;

  // Monitor: compare the oldest expectation against the live outputs.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_exp = q.pop_front();
      m_tag = tags.pop_front();
      m_act = {err, frame_start, pix_valid, hsync_o, vsync_o, pixel};
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s @%0t: got err=%b fs=%b pv=%b hs=%b vs=%b pix=%h, expected err=%b fs=%b pv=%b hs=%b vs=%b pix=%h",
                 m_tag, $time, m_act.err, m_act.fs, m_act.pv, m_act.hs, m_act.vs, m_act.pix,
                 m_exp.err, m_exp.fs, m_exp.pv, m_exp.hs, m_exp.vs, m_exp.pix);
      end
    end
  end

  // Reference model state: position, frame, running flag, latched timing.
  logic [15:0] mh, mv;
  logic [6:0]  mf;
  bit          mrun;
  logic        merr;
  logic [15:0] c_w, c_hf, c_hs, c_rw, c_h, c_vf, c_vs, c_rh;

  function automatic bit cfg_ok();
    return (width != 0) && (width <= hfront) && (hfront < hsync) && (hsync <= raw_width) &&
           (height != 0) && (height <= vfront) && (vfront < vsync) && (vsync <= raw_height);
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o.err = 1'b0; o.fs = 1'b0; o.pv = 1'b0;
    o.hs = INV_H; o.vs = INV_V; o.pix = '0;
    return o;
  endfunction

  function automatic obs_t run_obs();
    obs_t o;
    o.err = 1'b0;
    o.pv  = (mh < c_w) && (mv < c_h);
    o.hs  = ((mh >= c_hf) && (mh < c_hs)) ^ INV_H;
    o.vs  = ((mv >= c_vf) && (mv < c_vs)) ^ INV_V;
    o.pix = o.pv ? {mh[7:0], mv[7:0], mf} : 23'd0;
    o.fs  = o.pv && (mh == 0) && (mv == 0);
    return o;
  endfunction

  task automatic load_cfg();
    c_w = width; c_hf = hfront; c_hs = hsync; c_rw = raw_width;
    c_h = height; c_vf = vfront; c_vs = vsync; c_rh = raw_height;
  endtask

  task automatic model_clear();
    mrun = 1'b0; merr = 1'b0; mh = '0; mv = '0; mf = '0;
  endtask

  // One clock: predict the post-edge outputs from pre-edge inputs, then queue.
  task automatic tick(input string tag);
    obs_t e;
    bit   fend;
    e = idle_obs();
    if (!mrun) begin
      merr = !cfg_ok();
      if (en && cfg_ok()) begin
        mrun = 1'b1; load_cfg(); mh = '0; mv = '0; mf = '0;
      end
    end else begin
      fend = (mh == c_rw - 16'd1) && (mv == c_rh - 16'd1);
      if (!en) begin
        if (fend) merr = !cfg_ok();
        mrun = 1'b0; mh = '0; mv = '0; mf = '0;
      end else begin
        e = run_obs();
        if (fend) begin
          mh = '0; mv = '0; mf = mf + 7'd1;
          load_cfg();
          if (!cfg_ok()) begin mrun = 1'b0; merr = 1'b1; end
        end else if (mh == c_rw - 16'd1) begin
          mh = '0; mv = mv + 16'd1;
        end else begin
          mh = mh + 16'd1;
        end
      end
    end
    e.err = merr;
    @(posedge clk); #1;
    q.push_back(e); tags.push_back(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Advance until the model sits at (h,v) while running; expired bound is a failure.
  task automatic run_to(input logic [15:0] h, input logic [15:0] v, input string tag);
    int n = 0;
    while (!(mrun && mh == h && mv == v) && n < 500) begin
      tick(tag); n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL %s: position (%0d,%0d) not reached within 500 cycles", tag, h, v);
    end
  endtask

  initial begin
    model_clear();
    // Reset state while reset is held.
    repeat (2) begin
      @(posedge clk); #1;
      q.push_back(idle_obs()); tags.push_back("reset");
    end
    rst_n = 1'b1;
    width = 16'd4; hfront = 16'd5; hsync = 16'd6; raw_width = 16'd8;
    height = 16'd3; vfront = 16'd4; vsync = 16'd5; raw_height = 16'd6;
    ticks(2, "idle_valid");

    // Invalid configuration with enable high: error, no activity.
    hfront = 16'd3; en = 1'b1;
    ticks(10, "invalid_cfg");
    hfront = 16'd5;
    ticks(101, "small_mode");

    // Raw width change mid-frame applies from the next frame (60-clock frame).
    run_to(16'd3, 16'd1, "seek_change");
    raw_width = 16'd10;
    ticks(48 + 60 + 10, "mid_change");
    raw_width = 16'd8;
    ticks(80, "back_to_8");

    // Invalid timing presented at a wrap drops to idle with the error flag.
    hfront = 16'd3;
    ticks(70, "wrap_invalid");
    hfront = 16'd5;
    ticks(60, "recover");

    // Enable dropped mid-line, then re-enabled.
    run_to(16'd2, 16'd1, "seek_abort");
    en = 1'b0;
    ticks(3, "en_abort");
    en = 1'b1;
    ticks(20, "restart");

    // Asynchronous reset while a valid pixel is on the outputs.
    run_to(16'd2, 16'd1, "seek_reset");
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_clear();
    q.push_back(idle_obs()); tags.push_back("async_reset");
    @(posedge clk); #1;
    q.push_back(idle_obs()); tags.push_back("reset_hold");
    rst_n = 1'b1;
    ticks(60, "after_reset");

    // Frame counter wraps 127 -> 0.
    ticks(130 * 48 + 10, "frame_wrap");

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Programmable video timing and test-pattern source that drives the pixel/sync input side of the stream capture stage. It produces `o_pix_valid`, `o_hsync`, `o_vsync` and a 23-bit pattern pixel from run-time horizontal and vertical timing values. These values use the same cumulative convention as the capture stage's measured outputs (width, front-porch end, sync end, raw total), so a configuration read back from the capture stage can be written here unchanged. The block sits directly upstream of the capture stage in simulation and loopback builds.

## Interface
- `OPT_INVERT_HSYNC`, 1: when 1, `o_hsync` is active-low.
- `OPT_INVERT_VSYNC`, 1: when 1, `o_vsync` is active-low.
- `i_clk`  in  1  pixel clock; all logic is clocked on its rising edge.
- `i_reset_n`  in  1  **reset is asynchronous and active-low**; one clock domain only.
- `i_en`  in  1  run enable.
- `i_width`, `i_hfront`, `i_hsync`, `i_raw_width`  in  16 each  horizontal timing: active pixels, end of front porch, end of sync, total clocks per line.
- `i_height`, `i_vfront`, `i_vsync`, `i_raw_height`  in  16 each  vertical timing in lines, same convention.
- `o_pix_valid`  out  1  active pixel.
- `o_hsync`, `o_vsync`  out  1 each  sync outputs, polarity set by the `OPT_INVERT_*` parameters.
- `o_pixel`  out  23  test pattern `{hpos[7:0], vpos[7:0], frame[6:0]}`.
- `o_frame_start`  out  1  high together with pixel (0,0).
- `o_err`  out  1  the latched configuration is invalid.

## Operation
- **Internal state**
  - `hpos`, `vpos`: 16 bits each.
  - `frame`: 7 bits, wraps 127→0.
  - Shadow timing registers: eight 16-bit values.
  - State machine: `IDLE`, `RUN`.
- **Configuration check.** A configuration is valid iff both of the following hold:
  - `0 < width <= hfront < hsync <= raw_width`
  - `0 < height <= vfront < vsync <= raw_height`
  - All comparisons are unsigned 16-bit.
- **IDLE**
  - Counters are held at 0 and outputs are inactive.
  - Every cycle, the shadow registers load the `i_*` values and `o_err` is set to `!valid(i_*)`.
  - Go to RUN when `i_en && valid(i_*)`.
- **RUN**
  - `hpos` increments each clock. When `hpos == raw_width-1`, `hpos` goes to 0 and `vpos` increments.
  - When `vpos == raw_height-1` at a line end, `vpos` goes to 0 and `frame` increments.
- **Frame wrap.** At the wrap cycle the shadow registers reload from `i_*`.
  - If the new values are invalid or `i_en == 0`, go to IDLE and set `o_err` as in IDLE.
  - Otherwise continue with the new timing.
  - Timing inputs that change mid-frame have no effect until the wrap.
- **`i_en` deasserted mid-frame.** Go to IDLE on the next clock. Counters clear, and the partial frame is abandoned.
- **Decode, registered one clock after the counters.**
  - `pv = (hpos < width) && (vpos < height)`
  - `hs = (hfront <= hpos < hsync)`
  - `vs = (vfront <= vpos < vsync)`
  - `o_hsync = hs ^ OPT_INVERT_HSYNC`, `o_vsync = vs ^ OPT_INVERT_VSYNC`
  - `o_pixel` is the pattern when `pv`, otherwise 0.
  - `o_frame_start = pv && hpos == 0 && vpos == 0`
- **Widths.** All comparisons are 16-bit. `hpos` never exceeds `raw_width-1` and `vpos` never exceeds `raw_height-1`, so counters cannot overflow.

## Timing
- **Reset values**
  - State IDLE; `hpos`, `vpos`, `frame` = 0.
  - `o_pix_valid = 0`, `o_pixel = 0`, `o_frame_start = 0`, `o_err = 0`.
  - `o_hsync = OPT_INVERT_HSYNC`, `o_vsync = OPT_INVERT_VSYNC` (both inactive).
- **Start-up.** `i_en` rises with a valid configuration at edge N. The state is RUN after edge N, and `o_pix_valid`/`o_frame_start` first read 1 after edge N+1, which is one cycle of output latency.
- **Frame period** is exactly `raw_width*raw_height` clocks. There are no dropped or extra clocks at wraps.
- **Reset mid-frame** clears everything immediately (asynchronous). Outputs return to their reset values without waiting for a clock.
- **Simultaneous wrap and `i_en` fall:** go to IDLE. No new frame starts.
- There is no backpressure. The output is free-running, matching the capture stage, which ignores TREADY.

## Test plan
- **Small mode.** Config: width 4, hfront 5, hsync 6, raw_width 8; height 3, vfront 4, vsync 5, raw_height 6; `i_en = 1`.
  - Per line: 4 valid cycles, then `o_hsync` low for exactly 1 cycle (hpos 5).
  - `o_vsync` low for line 4 only.
  - `o_frame_start` repeats every 48 clocks.
  - `o_pixel` at (2,1) in frame 0 is `{8'd2, 8'd1, 7'd0}`.
- **Loopback.** Feed the small mode into the capture stage. After 2 frames it must report width 4, hfront 5, hsync 6, raw_width 8, height 3, raw_height 6, locked.
- **Invalid configuration.** Set hfront 3 < width 4 with `i_en = 1`: `o_err = 1`, `o_pix_valid` stays 0, and no sync pulses appear. Fix hfront to 5: RUN starts and `o_err` clears.
- **Mid-frame change.** Change `i_raw_width` 8→10 at hpos 3, vpos 1: the current frame keeps 8-clock lines, and the next frame uses 10-clock lines (frame period 60).
- **Enable and reset abort.** Drop `i_en` mid-line: outputs go inactive on the next clock; re-enabling restarts at (0,0). Assert `i_reset_n = 0` asynchronously mid-frame: all outputs take their reset values before the next clock edge.
- **Frame counter wrap.** Run 128 frames: the pattern `frame` field wraps 127→0, and `o_frame_start` appears exactly once per frame.
